// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: 7-bit program counter, 128x16 program ROM with a
// registered read port, and a 16-bit instruction register for the controller.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_clr,
    input  logic        pc_up,
    input  logic        ir_ld,
    output logic [6:0]  pc_out,
    output logic [15:0] mem_data,
    output logic [15:0] ir_out
);

    // Opcodes in instruction bits [15:12]
    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    logic [6:0]  pc_q,  pc_d;
    logic [15:0] mem_q, mem_d;
    logic [15:0] ir_q,  ir_d;

    // Read-only program image; every address past the HALT is a NOOP.
    function automatic logic [15:0] rom_word(input logic [6:0] addr);
        logic [15:0] w;
        case (addr)
            7'd0:    w = {OP_LOAD,  8'd11,  4'd1};   // R1 <- DM[11]
            7'd1:    w = {OP_LOAD,  8'd27,  4'd2};   // R2 <- DM[27]
            7'd2:    w = {OP_LOAD,  8'd6,   4'd3};   // R3 <- DM[6]
            7'd3:    w = {OP_LOAD,  8'd138, 4'd4};   // R4 <- DM[138]
            7'd4:    w = {OP_SUB,   4'd1, 4'd4, 4'd5}; // R5 <- R1 - R4
            7'd5:    w = {OP_SUB,   4'd3, 4'd2, 4'd6}; // R6 <- R3 - R2
            7'd6:    w = {OP_ADD,   4'd5, 4'd6, 4'd0}; // R0 <- R5 + R6
            7'd7:    w = {OP_STORE, 8'd205, 4'd0};   // DM[205] <- R0
            7'd8:    w = {OP_HALT,  12'h000};
            default: w = {OP_NOOP,  12'h000};
        endcase
        return w;
    endfunction

    // Next-state: clear beats increment; increment wraps naturally at 7 bits.
    // ROM data always follows the current PC, one cycle later.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        mem_d = rom_word(pc_q);
        if (pc_clr)
            pc_d = '0;
        else if (pc_up)
            pc_d = pc_q + 7'd1;
        if (ir_ld)
            ir_d = mem_q;
    end

    // State registers; reset touches PC and IR only, the ROM read keeps tracking.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign pc_out   = pc_q;
    assign mem_data = mem_q;
    assign ir_out   = ir_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed program fetch, boundary
// cases and random control traffic against a cycle-level reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0, pc_clr = 1'b0, pc_up = 1'b0, ir_ld = 1'b0;
    logic [6:0]  pc_out;
    logic [15:0] mem_data, ir_out;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_clr(pc_clr), .pc_up(pc_up), .ir_ld(ir_ld),
        .pc_out(pc_out), .mem_data(mem_data), .ir_out(ir_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state; *_k marks whether the value is defined yet.
    logic [15:0] rom_ref [128];
    int          pc_m = 0;
    logic [15:0] ir_m = '0, mem_m = '0;
    bit          pc_k = 0, ir_k = 0, mem_k = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of controls, advance the model, compare after the edge.
    task automatic cycle(input bit r, input bit clr, input bit up, input bit ld);
        int          pc_n;
        logic [15:0] ir_n, mem_n;
        bit          pc_kn, ir_kn, mem_kn;
        reset = r; pc_clr = clr; pc_up = up; ir_ld = ld;
        mem_n = rom_ref[pc_m]; mem_kn = pc_k;
        if (r)        begin ir_n = '0;    ir_kn = 1;     end
        else if (ld)  begin ir_n = mem_m; ir_kn = mem_k; end
        else          begin ir_n = ir_m;  ir_kn = ir_k;  end
        if (r || clr) begin pc_n = 0;                  pc_kn = 1;    end
        else if (up)  begin pc_n = (pc_m + 1) % 128;   pc_kn = pc_k; end
        else          begin pc_n = pc_m;               pc_kn = pc_k; end
        @(posedge clk);
        #1;
        pc_m = pc_n; ir_m = ir_n; mem_m = mem_n;
        pc_k = pc_kn; ir_k = ir_kn; mem_k = mem_kn;
        if (pc_k)  chk("pc",  32'(pc_out),   32'(pc_m));
        if (ir_k)  chk("ir",  32'(ir_out),   32'(ir_m));
        if (mem_k) chk("mem", 32'(mem_data), 32'(mem_m));
    endtask

    logic [15:0] prog [9];
    int          last_pc;

    initial begin
        prog[0] = 16'h20B1; prog[1] = 16'h21B2; prog[2] = 16'h2063;
        prog[3] = 16'h28A4; prog[4] = 16'h4145; prog[5] = 16'h4326;
        prog[6] = 16'h3560; prog[7] = 16'h1CD0; prog[8] = 16'h5000;
        for (int i = 0; i < 128; i++) rom_ref[i] = (i < 9) ? prog[i] : 16'h0000;

        // Reset then one idle cycle
        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("rst_pc",  32'(pc_out),   32'd0);
        chk("rst_ir",  32'(ir_out),   32'h0000);
        chk("rst_mem", 32'(mem_data), 32'h20B1);

        // Fetch the whole program
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1, 1);
            chk($sformatf("fetch%0d", i), 32'(ir_out), 32'(prog[i]));
            cycle(0, 0, 0, 0);
            cycle(0, 0, 0, 0);
        end
        chk("final_pc", 32'(pc_out), 32'd9);

        // Halt hold
        repeat (3) cycle(0, 0, 0, 0);
        chk("halt_pc", 32'(pc_out), 32'd9);
        chk("halt_ir", 32'(ir_out), 32'h5000);

        // Clear beats increment at PC=5, then ir_ld alone
        cycle(0, 1, 0, 0);
        repeat (5) cycle(0, 0, 1, 0);
        chk("pre_clr_pc", 32'(pc_out), 32'd5);
        cycle(0, 1, 1, 0);
        chk("clr_up_pc", 32'(pc_out), 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        chk("ld_only_ir", 32'(ir_out), 32'h20B1);

        // Wrap: 130 increments from 0
        last_pc = 0;
        for (int i = 0; i < 130; i++) begin
            cycle(0, 0, 1, 0);
            if (last_pc == 127) chk("wrap_0", 32'(pc_out), 32'd0);
            last_pc = int'(pc_out);
        end
        chk("wrap_end_pc", 32'(pc_out), 32'd2);

        // Reset mid-run at PC=6 with pc_up and ir_ld
        cycle(0, 1, 0, 0);
        repeat (6) cycle(0, 0, 1, 0);
        chk("pre_rst_pc", 32'(pc_out), 32'd6);
        cycle(1, 0, 1, 1);
        chk("midrst_pc", 32'(pc_out), 32'd0);
        chk("midrst_ir", 32'(ir_out), 32'h0000);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                  1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: pc_clr  input  1  synchronous clear of the program counter.
REQ-005 Port: pc_up  input  1  increment the program counter by 1.
REQ-006 Port: ir_ld  input  1  load the instruction register from mem_data.
REQ-007 Port: pc_out  output  7  current program counter, which is the instruction memory address.
REQ-008 Port: mem_data  output  16  instruction memory read data.
REQ-009 Port: ir_out  output  16  instruction register contents, fed to the controller.

Function
REQ-010 PC SHALL be a 7-bit register that updates on rising clk with priority reset > pc_clr > pc_up > hold.
REQ-011 reset or pc_clr SHALL set PC to 0 at the next edge.
REQ-012 pc_up alone SHALL increment PC by 1 modulo 128, so 127 wraps to 0 with no flag.
REQ-013 pc_clr and pc_up asserted together SHALL clear the PC, with no increment.
REQ-014 Instruction memory SHALL be a 128x16 ROM with a registered read:
- mem_data at each edge takes ROM[pc_out as sampled at that edge].
- Latency from address to data is 1 cycle.
- reset does not clear mem_data.
REQ-015 ROM contents SHALL be as follows, using opcodes [15:12] NOOP=0, STORE=1, LOAD=2, ADD=3, SUB=4, HALT=5:
- LOAD: [11:4] data address, [3:0] destination register.
- STORE: [11:4] data address, [3:0] source register.
- ADD/SUB: [11:8] Ra, [7:4] Rb, [3:0] destination register.
REQ-016 ROM program:
- addr 0 = 0x20B1 (LOAD DM[11] -> R1)
- addr 1 = 0x21B2 (LOAD DM[27] -> R2)
- addr 2 = 0x2063 (LOAD DM[6] -> R3)
- addr 3 = 0x28A4 (LOAD DM[138] -> R4)
- addr 4 = 0x4145 (SUB R1 - R4 -> R5)
- addr 5 = 0x4326 (SUB R3 - R2 -> R6)
- addr 6 = 0x3560 (ADD R5 + R6 -> R0)
- addr 7 = 0x1CD0 (STORE R0 -> DM[205])
- addr 8 = 0x5000 (HALT)
- addr 9-127 = 0x0000 (NOOP)
REQ-017 IR SHALL be a 16-bit register with priority reset > ir_ld > hold:
- ir_ld loads the mem_data value present before the edge.
REQ-018 The controller fetch sequence SHALL be supported as follows:
- pc_up and ir_ld asserted in the same cycle load the IR with the instruction addressed by the pre-increment PC.
- This holds provided PC was stable for at least one prior cycle.
REQ-019 ROM contents SHALL be read-only, with no write port.

Reset
REQ-020 While reset is high at an edge:
- pc_out becomes 0 and ir_out becomes 0x0000.
- mem_data continues tracking ROM[pc_out].
REQ-021 One cycle after reset deasserts with pc_up=0, mem_data SHALL equal 0x20B1.
REQ-022 reset asserted mid-program SHALL override pc_up, pc_clr and ir_ld at that edge.
REQ-023 Outputs SHALL be undefined before the first reset edge; the bench SHALL reset for at least 2 cycles.

Verification
REQ-024 Reset 3 cycles, then idle 1 cycle -> pc_out=0, ir_out=0x0000, mem_data=0x20B1.
REQ-025 Per instruction: pc_up=1 and ir_ld=1 for 1 cycle, then 2 idle cycles, repeated 9 times.
- ir_out sequence: 0x20B1, 0x21B2, 0x2063, 0x28A4, 0x4145, 0x4326, 0x3560, 0x1CD0, 0x5000.
- Final pc_out = 9.
REQ-026 Halt hold: after ir_out=0x5000, all controls low for 3 cycles -> pc_out=9 and ir_out=0x5000 unchanged.
REQ-027 Clear/increment precedence:
- pc_clr=1 with pc_up=1 at PC=5 -> pc_out=0.
- ir_ld alone -> ir_out=0x20B1.
REQ-028 Wrap: pc_up held for 130 cycles from 0 -> pc_out passes 127 -> 0 -> 1 -> 2, and mem_data=0x0000 for addresses 9-127.
REQ-029 Reset mid-run: at PC=6 assert reset together with pc_up and ir_ld -> pc_out=0 and ir_out=0x0000 at that edge.
